// File: rtl/cdc_sched_pkg.sv
// Shared types and defaults for the pulse-CDC scheduler.
`timescale 1ns/1ps
package cdc_sched_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } sched_state_e;

    localparam int GAP_CYCLES_DEF = 6;

    // An index field is at least one bit wide, even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
`timescale 1ns/1ps
module rr_arbiter
    import cdc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cdc_pulse_scheduler.sv
// Shares one pulse-CDC channel between NUM_REQ requesters with launch spacing.
// Build option: define CDC_SCHED_ACK_EN to end the hold window on ack_i instead of a counter.
`timescale 1ns/1ps
module cdc_pulse_scheduler
    import cdc_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int ID_W       = id_width(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [NUM_REQ-1:0]        req_pulse_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic                      clr_ovf_i,
`ifdef CDC_SCHED_ACK_EN
    input  logic                      ack_i,
`endif
    output logic                      sync_pulse_o,
    output logic [DATA_W-1:0]         sync_data_o,
    output logic [ID_W-1:0]           sync_id_o,
    output logic                      busy_o,
    output logic [NUM_REQ-1:0]        pending_o,
    output logic [NUM_REQ-1:0]        overflow_o
);

    sched_state_e          state_q;
    logic [ID_W-1:0]       ptr_q;
    logic [NUM_REQ-1:0]    pending_q;
    logic [NUM_REQ-1:0]    overflow_q;
    logic [DATA_W-1:0]     slot_data [NUM_REQ];

    logic                  gnt_valid;
    logic [ID_W-1:0]       gnt_idx;
    logic                  launch;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [NUM_REQ-1:0]    capture;
    logic [NUM_REQ-1:0]    new_ovf;

`ifndef CDC_SCHED_ACK_EN
    localparam int CNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    logic [CNT_W-1:0]      cnt_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (pending_q),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign launch = (state_q == S_IDLE) && gnt_valid;

    // A slot being granted this edge counts as free, so a same-edge refill is not an overflow.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (launch && (gnt_idx == ID_W'(i))) grant_oh[i] = 1'b1;
        end
        capture = req_pulse_i & (~pending_q | grant_oh);
        new_ovf = req_pulse_i & pending_q & ~grant_oh;
    end

    // NOTE: slot payloads are not reset; pending_q guards every read, so only the flags need a reset value.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) slot_data[i] <= req_data_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= (pending_q & ~grant_oh) | capture;
            overflow_q <= (clr_ovf_i ? '0 : overflow_q) | new_ovf;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            sync_pulse_o <= 1'b0;
            sync_data_o  <= '0;
            sync_id_o    <= '0;
`ifndef CDC_SCHED_ACK_EN
            cnt_q        <= '0;
`endif
        end else begin
            sync_pulse_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        sync_pulse_o <= 1'b1;
                        sync_data_o  <= slot_data[gnt_idx];
                        sync_id_o    <= gnt_idx;
                        ptr_q        <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`ifndef CDC_SCHED_ACK_EN
                        cnt_q        <= CNT_W'(GAP_CYCLES - 1);
`endif
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
`ifdef CDC_SCHED_ACK_EN
                    if (ack_i) state_q <= S_IDLE;
`else
                    // Leaving at count 1 makes the next launch exactly GAP_CYCLES after this one.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q == S_HOLD);
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Directed self-checking bench for cdc_pulse_scheduler (NUM_REQ=4, DATA_W=8, GAP_CYCLES=6).
`timescale 1ns/1ps
module tb_cdc_pulse_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      arst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] rdata;
    logic                      clr;
`ifdef CDC_SCHED_ACK_EN
    logic                      ack;
`endif
    logic                      sync_pulse;
    logic [DATA_W-1:0]         sync_data;
    logic [ID_W-1:0]           sync_id;
    logic                      busy;
    logic [NUM_REQ-1:0]        pending;
    logic [NUM_REQ-1:0]        overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cdc_pulse_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .GAP_CYCLES (6),
        .ID_W       (ID_W)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_pulse_i  (req),
        .req_data_i   (rdata),
        .clr_ovf_i    (clr),
`ifdef CDC_SCHED_ACK_EN
        .ack_i        (ack),
`endif
        .sync_pulse_o (sync_pulse),
        .sync_data_o  (sync_data),
        .sync_id_o    (sync_id),
        .busy_o       (busy),
        .pending_o    (pending),
        .overflow_o   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DATA_W-1:0] v);
        rdata[idx*DATA_W +: DATA_W] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulse"},    32'(sync_pulse), 0);
        chk({tag, "_data"},     32'(sync_data),  0);
        chk({tag, "_id"},       32'(sync_id),    0);
        chk({tag, "_busy"},     32'(busy),       0);
        chk({tag, "_pending"},  32'(pending),    0);
        chk({tag, "_overflow"}, 32'(overflow),   0);
    endtask

    task automatic do_reset();
        arst  = 1'b1;
        req   = '0;
        clr   = 1'b0;
        rdata = '0;
`ifdef CDC_SCHED_ACK_EN
        ack   = 1'b0;
`endif
        tick();
        tick();
        arst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [3:0] pexp;
        logic       seen;
        int         ids4 [4];
        int         dat4 [4];
        int         k;

        // ---- Reset state --------------------------------------------------
        arst  = 1'b1;
        req   = '0;
        clr   = 1'b0;
        rdata = '0;
`ifdef CDC_SCHED_ACK_EN
        ack   = 1'b0;
`endif
        #2;
        chk_all_zero("rst");
        tick();
        tick();
        arst = 1'b0;

        // ---- 1: single request, latency 2, hold window ---------------------
        req = 4'b0001;
        set_data(0, 8'hA5);
        tick();                                   // cycle 1
        req = '0;
        chk("t1_c1_pulse",   32'(sync_pulse), 0);
        chk("t1_c1_pending", 32'(pending),    'h1);
        chk("t1_c1_busy",    32'(busy),       0);
        tick();                                   // cycle 2
        chk("t1_pulse",   32'(sync_pulse), 1);
        chk("t1_data",    32'(sync_data),  'hA5);
        chk("t1_id",      32'(sync_id),    0);
        chk("t1_busy",    32'(busy),       1);
        chk("t1_pending", 32'(pending),    0);
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk("t1_hold_pulse", 32'(sync_pulse), 0);
            chk("t1_hold_busy",  32'(busy),       1);
        end
        tick();                                   // cycle 7: back in IDLE
        chk("t1_c7_busy", 32'(busy),      0);
        chk("t1_c7_data", 32'(sync_data), 'hA5);

        // ---- 2: four simultaneous requests, spacing 6 ----------------------
        do_reset();
        req = 4'b1111;
        set_data(0, 8'h10);
        set_data(1, 8'h20);
        set_data(2, 8'h30);
        set_data(3, 8'h40);
        for (int c = 1; c <= 21; c++) begin
            tick();
            req = '0;
            if (c == 1) chk("t2_c1_pending", 32'(pending), 'hF);
            if (c >= 2 && ((c - 2) % 6) == 0) begin
                k    = (c - 2) / 6;
                pexp = 4'(15 << (k + 1));
                chk("t2_pulse",   32'(sync_pulse), 1);
                chk("t2_id",      32'(sync_id),    k);
                chk("t2_data",    32'(sync_data),  'h10 * (k + 1));
                chk("t2_pending", 32'(pending),    32'(pexp));
            end else begin
                chk("t2_nopulse", 32'(sync_pulse), 0);
            end
        end

        // ---- 3: overflow, same-edge refill, overflow clear ----------------
        do_reset();
        req = 4'b0001;
        set_data(0, 8'h11);
        tick();                                   // cycle 1
        req = 4'b0010;
        set_data(1, 8'h21);
        tick();                                   // cycle 2
        chk("t3_pulse0", 32'(sync_pulse), 1);
        chk("t3_id0",    32'(sync_id),    0);
        chk("t3_data0",  32'(sync_data),  'h11);
        req = 4'b0010;
        set_data(1, 8'h22);
        tick();                                   // cycle 3
        req = '0;
        chk("t3_ovf_set", 32'(overflow), 'h2);
        chk("t3_pending", 32'(pending),  'h2);
        repeat (4) tick();                        // cycle 7
        chk("t3_c7_busy", 32'(busy), 0);
        req = 4'b0010;
        set_data(1, 8'h23);
        tick();                                   // cycle 8
        req = '0;
        chk("t3_pulse1",      32'(sync_pulse), 1);
        chk("t3_id1",         32'(sync_id),    1);
        chk("t3_data_kept",   32'(sync_data),  'h21);
        chk("t3_refill_pend", 32'(pending),    'h2);
        chk("t3_ovf_sticky",  32'(overflow),   'h2);
        clr = 1'b1;
        tick();                                   // cycle 9
        clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 0);
        repeat (5) tick();                        // cycle 14
        chk("t3_pulse2",   32'(sync_pulse), 1);
        chk("t3_id2",      32'(sync_id),    1);
        chk("t3_data2",    32'(sync_data),  'h23);
        chk("t3_pend_end", 32'(pending),    0);

        // ---- 4: round-robin fairness between requesters 0 and 2 -----------
        do_reset();
        ids4 = '{0, 2, 0, 2};
        dat4 = '{'hA0, 'hC0, 'hA2, 'hC8};
        req  = 4'b0101;
        set_data(0, 8'hA0);
        set_data(2, 8'hC0);
        tick();                                   // cycle 1
        req = '0;
        for (int c = 2; c <= 20; c++) begin
            tick();
            req = '0;
            if (((c - 2) % 6) == 0) begin
                k = (c - 2) / 6;
                chk("t4_pulse", 32'(sync_pulse), 1);
                chk("t4_id",    32'(sync_id),    ids4[k]);
                chk("t4_data",  32'(sync_data),  dat4[k]);
                // Re-arm the requester just served with a fresh payload.
                req = 4'(1 << ids4[k]);
                set_data(ids4[k], 8'((ids4[k] == 0 ? 'hA0 : 'hC0) + c));
            end else begin
                chk("t4_nopulse", 32'(sync_pulse), 0);
            end
        end

        // ---- 5: reset in the middle of HOLD -------------------------------
        do_reset();
        req = 4'b0111;
        set_data(0, 8'h01);
        set_data(1, 8'h02);
        set_data(2, 8'h03);
        tick();                                   // cycle 1
        req = '0;
        tick();                                   // cycle 2
        chk("t5_pulse", 32'(sync_pulse), 1);
        tick();
        tick();                                   // cycle 4
        chk("t5_busy",    32'(busy),    1);
        chk("t5_pending", 32'(pending), 'h6);
        #2;
        arst = 1'b1;
        #1;
        chk_all_zero("t5_async");
        tick();
        arst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (sync_pulse) seen = 1'b1;
        end
        chk("t5_no_resend", 32'(seen),    0);
        chk("t5_pend_lost", 32'(pending), 0);
        req = 4'b1000;
        set_data(3, 8'h3C);
        tick();
        req = '0;
        tick();
        chk("t5_new_pulse", 32'(sync_pulse), 1);
        chk("t5_new_id",    32'(sync_id),    3);
        chk("t5_new_data",  32'(sync_data),  'h3C);

`ifdef CDC_SCHED_ACK_EN
        // ---- 6: ack-terminated hold ---------------------------------------
        do_reset();
        req = 4'b0011;
        set_data(0, 8'h61);
        set_data(1, 8'h62);
        tick();                                   // cycle 1
        req = '0;
        tick();                                   // cycle 2
        chk("t6_pulse0", 32'(sync_pulse), 1);
        chk("t6_id0",    32'(sync_id),    0);
        seen = 1'b0;
        for (int c = 3; c <= 12; c++) begin
            tick();
            if (sync_pulse) seen = 1'b1;
        end
        chk("t6_no_timed_pulse", 32'(seen), 0);
        chk("t6_c12_busy",       32'(busy), 1);
        ack = 1'b1;
        tick();                                   // cycle 13
        ack = 1'b0;
        chk("t6_c13_pulse", 32'(sync_pulse), 0);
        chk("t6_c13_busy",  32'(busy),       0);
        tick();                                   // cycle 14
        chk("t6_pulse1", 32'(sync_pulse), 1);
        chk("t6_id1",    32'(sync_id),    1);
        chk("t6_data1",  32'(sync_data),  'h62);
        repeat (6) tick();                        // cycle 20
        ack = 1'b1;
        tick();                                   // cycle 21
        ack = 1'b0;
        chk("t6_idle_again", 32'(busy), 0);
        ack = 1'b1;                               // ack while IDLE must be ignored
        tick();
        ack = 1'b0;
        req = 4'b0001;
        set_data(0, 8'h77);
        tick();
        req = '0;
        tick();
        chk("t6_pulse2", 32'(sync_pulse), 1);
        chk("t6_data2",  32'(sync_data),  'h77);
        repeat (8) tick();
        chk("t6_stray_ack_ignored", 32'(busy), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
